// File: rtl/reflet_uart_loader.sv
// reflet_uart_loader: receives a framed, checksummed program over UART, writes it into instruction RAM,
// acks with 'K' or 'E', and holds the CPU in reset until an image loads cleanly.
module reflet_uart_loader #(
    parameter int clk_freq     = 1000000,
    parameter int baud_rate    = 9600,
    parameter int addr_size    = 7,
    parameter int program_size = 128,
    parameter int timeout_bits = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    output logic [addr_size-1:0] mem_addr,
    output logic [7:0]           mem_data,
    output logic                 mem_write_en,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 error
);
    localparam int bit_period = clk_freq / baud_rate;
    localparam int cw = $clog2(bit_period);
    localparam int tmo_max = timeout_bits * bit_period;
    localparam int tw = $clog2(tmo_max + 1);
    localparam logic [cw-1:0] full_cnt = cw'(bit_period - 1);
    localparam logic [cw-1:0] half_cnt = cw'(bit_period / 2 - 1);
    localparam logic [tw-1:0] tmo_end = tw'(tmo_max);
    localparam logic [7:0] max_len = 8'(program_size);
    localparam logic [7:0] magic = 8'hA5;
    localparam logic [7:0] ack_ok = 8'h4B;
    localparam logic [7:0] ack_err = 8'h45;

    typedef enum logic [2:0] {IDLE, LENGTH, DATA, CHECK, ACK} state_t;

    state_t state;
    logic rx_s1, rx_s2, rx_prev, rx_on;
    logic [cw-1:0] rx_cnt, tx_cnt;
    logic [3:0] rx_bit, tx_bit;
    logic [7:0] rx_byte, len, cnt, sum;
    logic [8:0] tx_sh;
    logic [tw-1:0] tmo;
    logic valid;
    logic start_det, rx_stop, byte_ok, frame_err, in_xfer, len_bad, chk_done, chk_good, go_ack;

    always_comb begin
        start_det = !rx_on && rx_prev && !rx_s2;
        rx_stop   = rx_on && rx_cnt == '0 && rx_bit == 4'd9;
        byte_ok   = rx_stop && rx_s2;
        frame_err = rx_stop && !rx_s2;
        in_xfer   = state == LENGTH || state == DATA || state == CHECK;
        len_bad   = state == LENGTH && byte_ok && (rx_byte == '0 || rx_byte > max_len);
        chk_done  = state == CHECK && byte_ok;
        chk_good  = chk_done && rx_byte == sum;
        go_ack    = in_xfer && (frame_err || tmo == tmo_end || len_bad || chk_done);
    end

    // Bit 0 is the start bit (re-checked at mid-bit to reject glitches), 1..8 data, 9 stop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_on   <= 1'b0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_byte <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (start_det) begin
                rx_on  <= 1'b1;
                rx_cnt <= half_cnt;
                rx_bit <= '0;
            end else if (rx_on) begin
                if (rx_cnt != '0) begin
                    rx_cnt <= rx_cnt - 1'b1;
                end else begin
                    rx_cnt <= full_cnt;
                    rx_bit <= rx_bit + 4'd1;
                    if ((rx_bit == '0 && rx_s2) || rx_bit == 4'd9)
                        rx_on <= 1'b0;
                    else if (rx_bit != '0)
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tx           <= 1'b1;
            tx_sh        <= '1;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_write_en <= 1'b0;
            cpu_reset    <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            valid        <= 1'b0;
            len          <= '0;
            cnt          <= '0;
            sum          <= '0;
            tmo          <= '0;
        end else begin
            mem_write_en <= 1'b0;
            tmo <= (!in_xfer || start_det) ? '0 : tmo + 1'b1;
            if (go_ack) begin
                // Start bit goes out on the cycle right after the deciding event.
                state  <= ACK;
                error  <= !chk_good;
                valid  <= chk_good;
                tx     <= 1'b0;
                tx_sh  <= {1'b1, chk_good ? ack_ok : ack_err};
                tx_bit <= '0;
                tx_cnt <= full_cnt;
            end else begin
                case (state)
                    IDLE: if (byte_ok && rx_byte == magic) begin
                        state     <= LENGTH;
                        cpu_reset <= 1'b0;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        valid     <= 1'b0;
                        cnt       <= '0;
                        sum       <= '0;
                    end
                    LENGTH: if (byte_ok) begin
                        len   <= rx_byte;
                        state <= DATA;
                    end
                    DATA: if (byte_ok) begin
                        mem_addr     <= addr_size'(cnt);
                        mem_data     <= rx_byte;
                        mem_write_en <= 1'b1;
                        cnt          <= cnt + 8'd1;
                        sum          <= sum + rx_byte;
                        if (cnt + 8'd1 == len)
                            state <= CHECK;
                    end
                    ACK: if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else if (tx_bit == 4'd9) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cpu_reset <= valid;
                    end else begin
                        tx     <= tx_sh[0];
                        tx_sh  <= {1'b1, tx_sh[8:1]};
                        tx_bit <= tx_bit + 4'd1;
                        tx_cnt <= full_cnt;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_reflet_uart_loader.sv
// tb_reflet_uart_loader: drives framed UART images and checks writes, ack bytes and status
// against a frame-level reference model.
`timescale 1ns/1ps
module tb_reflet_uart_loader;
    localparam int bp = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic tx, mem_write_en, cpu_reset, busy, error;
    logic [6:0] mem_addr;
    logic [7:0] mem_data;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reflet_uart_loader #(
        .clk_freq(1000000), .baud_rate(100000), .addr_size(7), .program_size(128), .timeout_bits(64)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_write_en(mem_write_en), .cpu_reset(cpu_reset), .busy(busy), .error(error)
    );

    logic [14:0] wq[$];
    logic [7:0] dut_mem[128];
    logic [8:0] txq[$];
    int strobe_viol = 0;
    int busy_cycles = 0;
    logic we_prev = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b1 && mem_write_en === 1'b1) begin
            wq.push_back({mem_addr, mem_data});
            dut_mem[mem_addr] = mem_data;
        end
        if (mem_write_en === 1'b1 && we_prev === 1'b1) strobe_viol++;
        we_prev = mem_write_en;
        if (busy === 1'b1) busy_cycles++;
    end

    initial forever begin
        logic [7:0] b;
        @(negedge tx);
        repeat (bp / 2) @(posedge clk);
        #1;
        if (tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (bp) @(posedge clk);
                #1 b[i] = tx;
            end
            repeat (bp) @(posedge clk);
            #1 txq.push_back({tx, b});
        end
    end

    logic [7:0] ref_mem[128];
    logic [14:0] exp_wq[$];
    logic [7:0] exp_rep;
    bit exp_err, exp_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: f holds the bytes the loader received intact, starting with the magic byte.
    task automatic model(input logic [7:0] f[$], input bit aborted);
        int n;
        logic [7:0] s;
        s = 8'd0;
        n = int'(f[1]);
        exp_wq = {};
        exp_rep = 8'h45;
        exp_err = 1'b1;
        exp_run = 1'b0;
        if (n == 0 || n > 128) return;
        for (int i = 0; i < n && i + 2 < f.size(); i++) begin
            exp_wq.push_back({7'(i), f[i+2]});
            ref_mem[i] = f[i+2];
            s = s + f[i+2];
        end
        if (!aborted && f.size() > n + 2 && f[n+2] == s) begin
            exp_rep = 8'h4B;
            exp_err = 1'b0;
            exp_run = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (bp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bp) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (bp) @(negedge clk);
        rx = 1'b1;
        repeat ($urandom_range(1, 3) * bp) @(negedge clk);
    endtask

    task automatic finish_frame(input string tag, input int w0, input int t0);
        int k, bad;
        logic early;
        logic [31:0] got;
        k = 0;
        early = 1'b0;
        while (txq.size() <= t0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (txq.size() > t0) got = 32'(txq[t0]);
        else got = 32'hDEAD;
        chk({tag, " reply"}, got, {23'd0, 1'b1, exp_rep});
        chk({tag, " busy_in_ack"}, 32'(busy), 32'd1);
        k = 0;
        while (busy === 1'b1 && k < 4 * bp) begin
            if (cpu_reset !== 1'b0) early = 1'b1;
            @(negedge clk);
            k++;
        end
        chk({tag, " busy_done"}, 32'(busy), 32'd0);
        chk({tag, " cpu_early"}, 32'(early), 32'd0);
        chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'(exp_run));
        chk({tag, " error"}, 32'(error), 32'(exp_err));
        chk({tag, " nwrites"}, 32'(wq.size() - w0), 32'(exp_wq.size()));
        for (int i = 0; i < exp_wq.size() && w0 + i < wq.size(); i++)
            chk($sformatf("%s w%0d", tag, i), 32'(wq[w0+i]), 32'(exp_wq[i]));
        chk({tag, " strobe"}, 32'(strobe_viol), 32'd0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
        chk({tag, " mem"}, 32'(bad), 32'd0);
    endtask

    // bad >= 0 sends byte 'bad' with a low stop bit and stops there; cut marks a timed-out partial frame.
    task automatic run(input string tag, input logic [7:0] f[$], input int bad, input bit cut);
        int w0, t0;
        logic [7:0] g[$];
        w0 = wq.size();
        t0 = txq.size();
        for (int i = 0; i < f.size(); i++) if (bad < 0 || i < bad) g.push_back(f[i]);
        model(g, cut || bad >= 0);
        for (int i = 0; i < f.size() && (bad < 0 || i <= bad); i++) send_byte(f[i], i == bad);
        finish_frame(tag, w0, t0);
    endtask

    task automatic rand_frame(output logic [7:0] f[$], input int n, input bit good);
        logic [7:0] s, d;
        s = 8'd0;
        f = {8'hA5, 8'(n)};
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            f.push_back(d);
            s = s + d;
        end
        f.push_back(good ? s : s ^ 8'($urandom_range(1, 255)));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " tx"}, 32'(tx), 32'd1);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " mem_data"}, 32'(mem_data), 32'd0);
        chk({tag, " we"}, 32'(mem_write_en), 32'd0);
        chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
    endtask

    task automatic quiet(input string tag, input int w0, input int t0, input int b0);
        chk({tag, " no_reply"}, 32'(txq.size()), 32'(t0));
        chk({tag, " no_busy"}, 32'(busy_cycles), 32'(b0));
        chk({tag, " no_write"}, 32'(wq.size()), 32'(w0));
        chk({tag, " cpu_kept"}, 32'(cpu_reset), 32'(exp_run));
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] f[$];
        int w0, t0, b0;
        #3 reset = 1'b0;
        #20 check_reset_values("reset");
        reset = 1'b1;
        repeat (5) @(negedge clk);

        f = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run("good", f, -1, 1'b0);

        w0 = wq.size(); t0 = txq.size(); b0 = busy_cycles;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        repeat (3 * bp) @(negedge clk);
        quiet("garbage", w0, t0, b0);

        w0 = wq.size(); t0 = txq.size(); b0 = busy_cycles;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (15 * bp) @(negedge clk);
        quiet("glitch", w0, t0, b0);

        f = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h04};
        run("badsum", f, -1, 1'b0);
        f = {8'hA5, 8'h00};
        run("len0", f, -1, 1'b0);
        f = {8'hA5, 8'h81};
        run("len129", f, -1, 1'b0);
        rand_frame(f, 128, 1'b1);
        run("len128", f, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rand_frame(f, $urandom_range(1, 12), r % 3 != 2);
            run($sformatf("rand%0d", r), f, -1, 1'b0);
        end

        rand_frame(f, 4, 1'b1);
        run("framing", f, 3, 1'b0);

        f = {8'hA5, 8'h04, 8'h01};
        run("timeout", f, -1, 1'b1);
        rand_frame(f, 5, 1'b1);
        run("after_timeout", f, -1, 1'b0);

        rand_frame(f, 5, 1'b1);
        w0 = wq.size();
        model(f[0:3], 1'b1);
        for (int i = 0; i < 4; i++) send_byte(f[i], 1'b0);
        rx = 1'b0;
        repeat (4 * bp) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values("midreset");
        chk("midreset nwrites", 32'(wq.size() - w0), 32'd2);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2 * bp) @(negedge clk);
        rand_frame(f, 3, 1'b1);
        run("after_reset", f, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reflet_uart_loader.md
# reflet_uart_loader

Serial program loader that sits upstream of the 8-bit Reflet microcontroller's instruction memory. It holds the CPU in reset, receives a framed program image over a UART line, and writes it byte-by-byte into a writable instruction RAM. It verifies a checksum, replies with an ack byte, and releases the CPU. It replaces the fixed instruction ROM as the source of program contents.

## Interface
Parameters:
- clk_freq, 1000000: system clock frequency in Hz.
- baud_rate, 9600: UART bit rate. bit_period = clk_freq/baud_rate (integer division), must be ≥ 4.
- addr_size, 7: instruction memory address width.
- program_size, 128: maximum accepted image length in bytes, ≤ 2^addr_size and ≤ 255.
- timeout_bits, 64: abort a transfer if no start bit arrives for timeout_bits*bit_period cycles while mid-transfer.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- rx, input, 1: UART receive, 8N1, idle high. Double-flop synchronised internally.
- tx, output, 1: UART transmit, 8N1, idle high. Used only for the ack byte.
- mem_addr, output, addr_size: write address into instruction RAM.
- mem_data, output, 8: write data.
- mem_write_en, output, 1: one-cycle write strobe.
- cpu_reset, output, 1: active-low reset for the CPU/memory subsystem. 0 means CPU held.
- busy, output, 1: high from accepted magic byte until the ack has finished transmitting.
- error, output, 1: sticky. Set on any rejected transfer. Cleared when the next magic byte is accepted.

## Operation
- Receiver: detects the falling edge of the synchronised rx and re-checks it at bit_period/2. If rx is high there, the start is a glitch and is ignored. It samples 8 data bits (LSB first) at mid-bit, then the stop bit. A stop bit of 0 is a framing error: the byte is discarded and the transfer is aborted (if one is active).
- Frame format: 0xA5 magic, then length N, then N data bytes, then checksum C. C must equal (sum of data bytes) mod 256.
- FSM states: IDLE, LENGTH, DATA, CHECK, ACK.
- IDLE: any byte other than 0xA5 is ignored. On 0xA5: go to LENGTH, drop cpu_reset to 0, set busy, clear error, set byte counter to 0 and checksum to 0.
- LENGTH: if N==0 or N>program_size, set error and go to ACK with reply 0x45 ('E'). Otherwise latch N and go to DATA.
- DATA: for each byte, present mem_addr=counter and mem_data=byte, and pulse mem_write_en for one cycle. Then counter+1 and checksum+=byte (8-bit wrap). When counter reaches N, go to CHECK.
- CHECK: if the received C matches, reply 0x4B ('K') and mark the image valid. Otherwise set error and reply 'E'.
- ACK: transmit the reply byte (1 start, 8 data, 1 stop). On completion, clear busy. If the image is valid, drive cpu_reset to 1. Return to IDLE.
- Abort (framing error or timeout in LENGTH/DATA/CHECK): set error, reply 'E' through ACK, and keep cpu_reset at 0.
- Reload: a new 0xA5 in IDLE while the CPU runs drops cpu_reset again. Memory is overwritten from address 0. Addresses ≥ N keep their old contents.
- Bytes arriving during ACK are still received, but the FSM ignores them.

## Timing
- Reset values: tx=1, mem_addr=0, mem_data=0, mem_write_en=0, cpu_reset=0, busy=0, error=0, FSM=IDLE. The CPU stays held after reset until the first successful load.
- Reset asserted mid-operation: everything returns to the reset values immediately, including an in-progress tx byte, which is truncated to idle high.
- Byte-done latency: the stop-bit sample occurs 9.5 bit periods after the detected falling edge, plus 2 synchroniser cycles. mem_write_en asserts on the cycle after the stop-bit sample.
- mem_addr and mem_data are stable during the mem_write_en cycle and remain held until the next write.
- The ack tx start bit begins on the cycle after the checksum stop-bit sample. Each tx bit lasts exactly bit_period cycles. Total ack duration is 10*bit_period.
- cpu_reset rises on the same cycle busy falls.
- Timeout counter resets on every detected start bit and is active only in LENGTH, DATA and CHECK.

## Test plan
- Good load (clk_freq=1000000, baud=100000, 10 cycles/bit): send A5 03 11 22 33 66 -> writes 0x11@0, 0x22@1, 0x33@2, each a single-cycle strobe; tx sends 0x4B; cpu_reset rises with busy falling; error=0.
- Bad checksum: send A5 02 01 02 04 -> writes occur at 0,1; tx sends 0x45; error=1; cpu_reset stays 0.
- Length bounds: A5 00 and A5 81 (program_size=128) -> no writes, 'E', error=1. A5 80 followed by 128 bytes and a correct checksum -> last write @0x7F, 'K'.
- Noise/framing: 2-cycle low glitch on rx -> no byte received. Stop bit forced low on a data byte -> abort, 'E', error=1. Garbage 0x00 0xFF in IDLE -> ignored, busy stays 0.
- Timeout: A5 04 01, then silence for 64*10 cycles -> 'E', error=1, FSM back in IDLE. A subsequent valid frame loads correctly and clears error.
- Reset mid-transfer: drop reset during DATA -> all outputs return to their reset values at once. A following valid frame succeeds from address 0.
